// File: rtl/serv_bus_arb.sv
// Registered two-master Wishbone arbiter: merges SERV ibus and dbus onto one shared bus,
// round-robin on ties, with a watchdog that force-terminates unacknowledged cycles.
module serv_bus_arb #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        i_rst_n,

    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,

    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,

    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,

    output logic        o_timeout
);

    localparam int unsigned CW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit          WD_EN = (TIMEOUT != 0);
    // Counter is 0 in the first granted cycle, so expiry is at TIMEOUT-1.
    localparam logic [CW-1:0] LIMIT = (TIMEOUT == 0) ? CW'(0) : CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            last_dbus_q;
    logic [CW-1:0]   cnt_q;

    logic            req_c;
    logic            ack_c;
    logic            timeout_c;

    // Qualify the bus ack / watchdog with the granted master still holding its request.
    always_comb begin
        req_c = 1'b0;
        case (state_q)
            GNT_I:   req_c = i_ibus_cyc;
            GNT_D:   req_c = i_dbus_cyc;
            default: req_c = 1'b0;
        endcase
        ack_c     = req_c & i_wb_ack;
        timeout_c = req_c & ~i_wb_ack & WD_EN & (cnt_q == LIMIT);
    end

    // State register
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_ibus_cyc && i_dbus_cyc) begin
                    state_d = last_dbus_q ? GNT_I : GNT_D;
                end else if (i_ibus_cyc) begin
                    state_d = GNT_I;
                end else if (i_dbus_cyc) begin
                    state_d = GNT_D;
                end
            end
            GNT_I, GNT_D: begin
                if (!req_c || ack_c || timeout_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Combinational ack/data return
    always_comb begin
        o_ibus_ack = 1'b0;
        o_dbus_ack = 1'b0;
        o_timeout  = timeout_c;
        o_ibus_rdt = timeout_c ? 32'd0 : i_wb_rdt;
        o_dbus_rdt = timeout_c ? 32'd0 : i_wb_rdt;
        case (state_q)
            GNT_I:   o_ibus_ack = ack_c | timeout_c;
            GNT_D:   o_dbus_ack = ack_c | timeout_c;
            default: ;
        endcase
    end

    // Shared-bus request registers, grant history and watchdog counter
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wb_adr    <= 32'd0;
            o_wb_dat    <= 32'd0;
            o_wb_sel    <= 4'd0;
            o_wb_we     <= 1'b0;
            o_wb_cyc    <= 1'b0;
            last_dbus_q <= 1'b0;
            cnt_q       <= CW'(0);
        end else if (state_q == IDLE) begin
            if (state_d == GNT_I) begin
                o_wb_adr    <= i_ibus_adr;
                o_wb_dat    <= 32'd0;
                o_wb_sel    <= 4'hf;
                o_wb_we     <= 1'b0;
                o_wb_cyc    <= 1'b1;
                last_dbus_q <= 1'b0;
                cnt_q       <= CW'(0);
            end else if (state_d == GNT_D) begin
                o_wb_adr    <= i_dbus_adr;
                o_wb_dat    <= i_dbus_dat;
                o_wb_sel    <= i_dbus_sel;
                o_wb_we     <= i_dbus_we;
                o_wb_cyc    <= 1'b1;
                last_dbus_q <= 1'b1;
                cnt_q       <= CW'(0);
            end
        end else if (state_d == IDLE) begin
            o_wb_cyc <= 1'b0;
            o_wb_we  <= 1'b0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: tb/tb_serv_bus_arb.sv
// Randomized self-checking bench for serv_bus_arb against a transaction-level reference model.
module tb_serv_bus_arb;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] i_ibus_adr;
    logic        i_ibus_cyc;
    logic [31:0] o_ibus_rdt;
    logic        o_ibus_ack;
    logic [31:0] i_dbus_adr;
    logic [31:0] i_dbus_dat;
    logic [3:0]  i_dbus_sel;
    logic        i_dbus_we;
    logic        i_dbus_cyc;
    logic [31:0] o_dbus_rdt;
    logic        o_dbus_ack;
    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we;
    logic        o_wb_cyc;
    logic [31:0] i_wb_rdt;
    logic        i_wb_ack;
    logic        o_timeout;

    always #5 clk = ~clk;

    serv_bus_arb #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_ibus_adr (i_ibus_adr),
        .i_ibus_cyc (i_ibus_cyc),
        .o_ibus_rdt (o_ibus_rdt),
        .o_ibus_ack (o_ibus_ack),
        .i_dbus_adr (i_dbus_adr),
        .i_dbus_dat (i_dbus_dat),
        .i_dbus_sel (i_dbus_sel),
        .i_dbus_we  (i_dbus_we),
        .i_dbus_cyc (i_dbus_cyc),
        .o_dbus_rdt (o_dbus_rdt),
        .o_dbus_ack (o_dbus_ack),
        .o_wb_adr   (o_wb_adr),
        .o_wb_dat   (o_wb_dat),
        .o_wb_sel   (o_wb_sel),
        .o_wb_we    (o_wb_we),
        .o_wb_cyc   (o_wb_cyc),
        .i_wb_rdt   (i_wb_rdt),
        .i_wb_ack   (i_wb_ack),
        .o_timeout  (o_timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, how many cycles it has waited, and the bus contents.
    int          owner;      // 0 none, 1 ibus, 2 dbus
    int          waited;
    bit          last_was_d;
    logic [31:0] m_adr, m_dat;
    logic [3:0]  m_sel;
    bit          m_we, m_cyc;
    bit          e_iack, e_dack, e_to;
    logic [31:0] e_rdt;

    task automatic model_reset();
        owner = 0; waited = 0; last_was_d = 0;
        m_adr = 0; m_dat = 0; m_sel = 0; m_we = 0; m_cyc = 0;
        e_iack = 0; e_dack = 0; e_to = 0; e_rdt = 0;
    endtask

    task automatic predict();
        bit req;
        req    = (owner == 1 && i_ibus_cyc) || (owner == 2 && i_dbus_cyc);
        e_to   = req && !i_wb_ack && (TO != 0) && (waited + 1 == TO);
        e_iack = (owner == 1) && req && (i_wb_ack || e_to);
        e_dack = (owner == 2) && req && (i_wb_ack || e_to);
        e_rdt  = e_to ? 32'd0 : i_wb_rdt;
    endtask

    task automatic grant(input int who);
        owner = who; waited = 0; m_cyc = 1; last_was_d = (who == 2);
        if (who == 1) begin
            m_adr = i_ibus_adr; m_dat = 0; m_sel = 4'hf; m_we = 0;
        end else begin
            m_adr = i_dbus_adr; m_dat = i_dbus_dat; m_sel = i_dbus_sel; m_we = i_dbus_we;
        end
    endtask

    task automatic step();
        bit req;
        req = (owner == 1 && i_ibus_cyc) || (owner == 2 && i_dbus_cyc);
        if (owner == 0) begin
            if (i_ibus_cyc && i_dbus_cyc) grant(last_was_d ? 1 : 2);
            else if (i_ibus_cyc)          grant(1);
            else if (i_dbus_cyc)          grant(2);
        end else if (!req || e_iack || e_dack) begin
            owner = 0; m_cyc = 0; m_we = 0;
        end else begin
            waited++;
        end
    endtask

    task automatic compare();
        chk("wb_cyc", 32'(o_wb_cyc), 32'(m_cyc));
        chk("wb_adr", o_wb_adr, m_adr);
        chk("wb_dat", o_wb_dat, m_dat);
        chk("wb_sel", 32'(o_wb_sel), 32'(m_sel));
        chk("wb_we", 32'(o_wb_we), 32'(m_we));
        chk("ibus_ack", 32'(o_ibus_ack), 32'(e_iack));
        chk("dbus_ack", 32'(o_dbus_ack), 32'(e_dack));
        chk("timeout", 32'(o_timeout), 32'(e_to));
        if (e_iack) chk("ibus_rdt", o_ibus_rdt, e_rdt);
        if (e_dack) chk("dbus_rdt", o_dbus_rdt, e_rdt);
    endtask

    // Inputs are set at posedge+1; outputs checked at posedge+3; model advances at the edge.
    task automatic pre_tick();
        predict();
        #2;
        compare();
    endtask

    task automatic post_tick();
        @(posedge clk);
        step();
        #1;
    endtask

    task automatic tick();
        pre_tick();
        post_tick();
    endtask

    task automatic clear_inputs();
        i_ibus_adr = 0; i_ibus_cyc = 0;
        i_dbus_adr = 0; i_dbus_dat = 0; i_dbus_sel = 0; i_dbus_we = 0; i_dbus_cyc = 0;
        i_wb_rdt = 0; i_wb_ack = 0;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        i_rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] order [3];
    int          n_order;

    initial begin
        clear_inputs();
        do_reset();

        // Reset state, with a spurious slave ack that must be ignored
        i_wb_ack = 1; i_wb_rdt = 32'h1234;
        tick();
        chk("rst_cyc", 32'(o_wb_cyc), 32'd0);
        i_wb_ack = 0;

        // Single fetch
        i_ibus_adr = 32'h100; i_ibus_cyc = 1;
        tick();
        tick();
        i_wb_ack = 1; i_wb_rdt = 32'h13;
        pre_tick();
        chk("fetch_adr", o_wb_adr, 32'h100);
        chk("fetch_sel", 32'(o_wb_sel), 32'hf);
        chk("fetch_ack", 32'(o_ibus_ack), 32'd1);
        chk("fetch_rdt", o_ibus_rdt, 32'h13);
        chk("fetch_dack", 32'(o_dbus_ack), 32'd0);
        post_tick();
        clear_inputs();
        tick();

        // Store
        i_dbus_adr = 32'h2000; i_dbus_dat = 32'hdeadbeef; i_dbus_sel = 4'b0011;
        i_dbus_we = 1; i_dbus_cyc = 1;
        tick();
        for (int k = 0; k < 3; k++) begin
            i_wb_ack = (k == 2);
            pre_tick();
            chk("store_adr", o_wb_adr, 32'h2000);
            chk("store_dat", o_wb_dat, 32'hdeadbeef);
            chk("store_we", 32'(o_wb_we), 32'd1);
            chk("store_ack", 32'(o_dbus_ack), (k == 2) ? 32'd1 : 32'd0);
            post_tick();
        end
        clear_inputs();
        tick();

        // Tie round-robin from reset: dbus, ibus, dbus
        do_reset();
        i_ibus_adr = 32'ha0; i_dbus_adr = 32'hb0; i_ibus_cyc = 1; i_dbus_cyc = 1;
        n_order = 0;
        for (int c = 0; c < 9; c++) begin
            i_wb_ack = m_cyc;
            i_wb_rdt = $urandom;
            pre_tick();
            if (o_wb_cyc && n_order < 3) begin
                order[n_order] = o_wb_adr;
                n_order++;
            end
            post_tick();
        end
        chk("rr_count", 32'(n_order), 32'd3);
        chk("rr_0", order[0], 32'hb0);
        chk("rr_1", order[1], 32'ha0);
        chk("rr_2", order[2], 32'hb0);
        clear_inputs();
        tick();

        // Watchdog with no ack, then ack on the expiry cycle
        for (int pass = 0; pass < 2; pass++) begin
            i_ibus_adr = 32'h300; i_ibus_cyc = 1;
            tick();
            for (int k = 1; k <= int'(TO); k++) begin
                i_wb_ack = (pass == 1) && (k == int'(TO));
                i_wb_rdt = 32'h55;
                pre_tick();
                if (k == int'(TO)) begin
                    chk("wd_ack", 32'(o_ibus_ack), 32'd1);
                    chk("wd_to", 32'(o_timeout), (pass == 0) ? 32'd1 : 32'd0);
                    chk("wd_rdt", o_ibus_rdt, (pass == 0) ? 32'd0 : 32'h55);
                end else begin
                    chk("wd_early", 32'(o_timeout), 32'd0);
                end
                post_tick();
            end
            clear_inputs();
            pre_tick();
            chk("wd_cyc_after", 32'(o_wb_cyc), 32'd0);
            post_tick();
        end

        // Reset during a data grant, then a simultaneous pair goes to dbus
        i_dbus_adr = 32'h4000; i_dbus_dat = 32'h77; i_dbus_sel = 4'hf; i_dbus_we = 1; i_dbus_cyc = 1;
        tick();
        i_wb_ack = 1;
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_cyc", 32'(o_wb_cyc), 32'd0);
        chk("arst_we", 32'(o_wb_we), 32'd0);
        chk("arst_adr", o_wb_adr, 32'd0);
        chk("arst_dack", 32'(o_dbus_ack), 32'd0);
        chk("arst_iack", 32'(o_ibus_ack), 32'd0);
        model_reset();
        i_wb_ack = 0;
        i_ibus_adr = 32'h500; i_ibus_cyc = 1;
        @(negedge clk);
        i_rst_n = 1'b1;
        @(posedge clk);
        step();
        #1;
        pre_tick();
        chk("arst_tie_adr", o_wb_adr, 32'h4000);
        post_tick();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if (e_iack || !i_ibus_cyc) begin
                i_ibus_cyc = ($urandom_range(0, 9) < 5);
                i_ibus_adr = $urandom;
            end else if ($urandom_range(0, 49) == 0) begin
                i_ibus_cyc = 0;
            end
            if (e_dack || !i_dbus_cyc) begin
                i_dbus_cyc = ($urandom_range(0, 9) < 4);
                i_dbus_adr = $urandom;
                i_dbus_dat = $urandom;
                i_dbus_sel = 4'($urandom);
                i_dbus_we  = 1'($urandom);
            end else if ($urandom_range(0, 49) == 0) begin
                i_dbus_cyc = 0;
            end
            i_wb_ack = m_cyc ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
            i_wb_rdt = $urandom;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
